// File: rtl/fg_pkg.sv
// Shared widths, fixed-point constants and FSM encoding for the CORDIC front end
// of the function generator.
package fg_pkg;

    localparam int ANGLE_W   = 8;
    localparam int DATA_W    = 8;
    localparam int Q_FRAC    = 7;    // Q0.7: +/-1.0 is +/-pi for angles, full scale for data
    localparam int GAIN_COMP = 78;   // round(128 / 1.6468), cancels the CORDIC gain

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } seq_state_e;

    // (amp * GAIN_COMP) >>> Q_FRAC; the arithmetic shift floors toward -inf.
    function automatic logic [DATA_W-1:0] gain_comp(input logic [DATA_W-1:0] amp);
        logic signed [2*DATA_W-1:0] prod;
        prod = $signed({{DATA_W{amp[DATA_W-1]}}, amp}) * $signed((2*DATA_W)'(GAIN_COMP));
        return DATA_W'(prod >>> Q_FRAC);
    endfunction

endpackage

// File: rtl/fg_phase_acc.sv
// Phase accumulator: advances by the tuning word on every enabled sample tick and
// forms the 8-bit angle operand from its top byte plus the signed phase offset.
module fg_phase_acc
    import fg_pkg::*;
#(
    parameter int PHASE_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               adv_i,
    input  logic [PHASE_W-1:0] tune_word_i,
    input  logic [ANGLE_W-1:0] offset_i,
    output logic [ANGLE_W-1:0] z_o
);

    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] phase_d;

    always_comb begin
        phase_d = phase_q;
        if (adv_i) begin
            phase_d = phase_q + tune_word_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Modulo-256 add: wrapping past +pi lands on -pi, which the CORDIC handles.
    assign z_o = phase_q[PHASE_W-1 -: ANGLE_W] + offset_i;

endmodule

// File: rtl/cordic_phase_sequencer.sv
// Issues one CORDIC rotation per sample tick and holds the returned cos/sin pair.
// Define CORDIC_SEQ_GAIN_COMP_EN to pre-scale the amplitude by 1/K (78/128).
//
//   state | meaning
//   IDLE  | waiting for an enabled sample request
//   ISSUE | operands latched, start strobe high for this one cycle
//   WAIT  | waiting for the CORDIC done strobe or the timeout
module cordic_phase_sequencer
    import fg_pkg::*;
#(
    parameter int PHASE_W = 16,
    parameter int TIMEOUT = 15
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               enable_i,
    input  logic               sample_req_i,
    input  logic [PHASE_W-1:0] tune_word_i,
    input  logic [ANGLE_W-1:0] phase_offset_i,
    input  logic [DATA_W-1:0]  amplitude_i,
    output logic               cordic_strb_o,
    output logic [DATA_W-1:0]  cordic_x_o,
    output logic [DATA_W-1:0]  cordic_y_o,
    output logic [ANGLE_W-1:0] cordic_z_o,
    input  logic               cordic_strb_i,
    input  logic [DATA_W-1:0]  cordic_x_i,
    input  logic [DATA_W-1:0]  cordic_y_i,
    output logic [DATA_W-1:0]  cos_o,
    output logic [DATA_W-1:0]  sin_o,
    output logic               sample_valid_o,
    output logic               busy_o,
    output logic               overrun_o,
    output logic               timeout_o
);

    localparam int              TMR_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

    seq_state_e         state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [ANGLE_W-1:0] z_q, z_d;
    logic [DATA_W-1:0]  x_q, x_d;
    logic [DATA_W-1:0]  cos_q, cos_d;
    logic [DATA_W-1:0]  sin_q, sin_d;
    logic               valid_q, valid_d;
    logic               ovr_q, ovr_d;
    logic               tmo_q, tmo_d;
    logic               done_q, done_d;
    logic [DATA_W-1:0]  res_x_q, res_y_q;

    logic               req_en;
    logic [ANGLE_W-1:0] z_now;
    logic [DATA_W-1:0]  amp_term;

    assign req_en = sample_req_i & enable_i;

    fg_phase_acc #(
        .PHASE_W (PHASE_W)
    ) u_phase_acc (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .adv_i       (req_en),
        .tune_word_i (tune_word_i),
        .offset_i    (phase_offset_i),
        .z_o         (z_now)
    );

`ifdef CORDIC_SEQ_GAIN_COMP_EN
    assign amp_term = gain_comp(amplitude_i);
`else
    assign amp_term = amplitude_i;
`endif

    // The done strobe and results are registered once before use so the
    // CORDIC's outputs never feed the FSM decode directly.
    assign done_d = cordic_strb_i & (state_q == WAIT);

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        z_d     = z_q;
        x_d     = x_q;
        cos_d   = cos_q;
        sin_d   = sin_q;
        valid_d = 1'b0;
        tmo_d   = tmo_q;
        ovr_d   = ovr_q | (req_en & (state_q != IDLE));
        case (state_q)
            IDLE: begin
                if (req_en) begin
                    state_d = ISSUE;
                    z_d     = z_now;
                    x_d     = amp_term;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                tmr_d   = TMR_LOAD;
            end
            WAIT: begin
                if (done_q) begin
                    state_d = IDLE;
                    cos_d   = res_x_q;
                    sin_d   = res_y_q;
                    valid_d = 1'b1;
                end else if (tmr_q == '0) begin
                    state_d = IDLE;
                    tmo_d   = 1'b1;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            z_q     <= '0;
            x_q     <= '0;
            cos_q   <= '0;
            sin_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            tmo_q   <= 1'b0;
            done_q  <= 1'b0;
            res_x_q <= '0;
            res_y_q <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            z_q     <= z_d;
            x_q     <= x_d;
            cos_q   <= cos_d;
            sin_q   <= sin_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            tmo_q   <= tmo_d;
            done_q  <= done_d;
            res_x_q <= cordic_x_i;
            res_y_q <= cordic_y_i;
        end
    end

    assign cordic_strb_o  = (state_q == ISSUE);
    assign cordic_x_o     = x_q;
    assign cordic_y_o     = '0;
    assign cordic_z_o     = z_q;
    assign cos_o          = cos_q;
    assign sin_o          = sin_q;
    assign sample_valid_o = valid_q;
    assign busy_o         = (state_q != IDLE);
    assign overrun_o      = ovr_q;
    assign timeout_o      = tmo_q;

endmodule

// File: tb/tb_cordic_phase_sequencer.sv
// Self-checking bench for cordic_phase_sequencer with a behavioural CORDIC and a
// request-level reference model. Honours CORDIC_SEQ_GAIN_COMP_EN like the design.
module tb_cordic_phase_sequencer;

    localparam int PHASE_W = 16;
    localparam int T       = 15;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         enable_i;
    logic         sample_req_i;
    logic [15:0]  tune_word_i;
    logic [7:0]   phase_offset_i;
    logic [7:0]   amplitude_i;
    logic         cordic_strb_o;
    logic [7:0]   cordic_x_o, cordic_y_o, cordic_z_o;
    logic         cordic_strb_i;
    logic [7:0]   cordic_x_i, cordic_y_i;
    logic [7:0]   cos_o, sin_o;
    logic         sample_valid_o, busy_o, overrun_o, timeout_o;

    cordic_phase_sequencer #(
        .PHASE_W (PHASE_W),
        .TIMEOUT (T)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .enable_i       (enable_i),
        .sample_req_i   (sample_req_i),
        .tune_word_i    (tune_word_i),
        .phase_offset_i (phase_offset_i),
        .amplitude_i    (amplitude_i),
        .cordic_strb_o  (cordic_strb_o),
        .cordic_x_o     (cordic_x_o),
        .cordic_y_o     (cordic_y_o),
        .cordic_z_o     (cordic_z_o),
        .cordic_strb_i  (cordic_strb_i),
        .cordic_x_i     (cordic_x_i),
        .cordic_y_i     (cordic_y_i),
        .cos_o          (cos_o),
        .sin_o          (sin_o),
        .sample_valid_o (sample_valid_o),
        .busy_o         (busy_o),
        .overrun_o      (overrun_o),
        .timeout_o      (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Reference model state
    logic [15:0] m_phase;
    logic [7:0]  m_z, m_x;
    bit          m_ovr;
    int          free_edge;
    int          exp_valid = 0;

    // Behavioural CORDIC: ideal unity-gain rotation, done strobe 8 cycles after it
    // samples the start strobe.
    bit          cordic_mute = 1'b0;
    int          spur_cnt = 0;
    logic [7:0]  resp_cos = '0, resp_sin = '0;
    int          valid_cnt = 0;

    function automatic logic [7:0] rot(input int x, input int z, input bit want_sin);
        real a, r;
        int  v;
        a = real'(z) * 3.14159265358979 / 128.0;
        r = want_sin ? real'(x) * $sin(a) : real'(x) * $cos(a);
        v = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
        if (v > 127)  v = 127;
        if (v < -128) v = -128;
        return 8'(v);
    endfunction

    function automatic logic [7:0] exp_x(input logic [7:0] amp);
`ifdef CORDIC_SEQ_GAIN_COMP_EN
        int p;
        p = int'($signed(amp)) * 78;
        return 8'((p >= 0) ? p / 128 : -((-p + 127) / 128));
`else
        return amp;
`endif
    endfunction

    initial begin
        int xs, zs, spur_done;
        spur_done     = 0;
        cordic_strb_i = 1'b0;
        cordic_x_i    = '0;
        cordic_y_i    = '0;
        forever begin
            @(negedge clk_i);
            if (spur_cnt != spur_done) begin
                spur_done = spur_cnt;
                cordic_x_i = 8'h33;
                cordic_y_i = 8'h44;
                cordic_strb_i = 1'b1;
                @(negedge clk_i);
                cordic_strb_i = 1'b0;
            end else if (cordic_strb_o && !cordic_mute) begin
                xs = int'($signed(cordic_x_o));
                zs = int'($signed(cordic_z_o));
                repeat (9) @(posedge clk_i);
                #1;
                resp_cos = rot(xs, zs, 1'b0);
                resp_sin = rot(xs, zs, 1'b1);
                cordic_x_i = resp_cos;
                cordic_y_i = resp_sin;
                cordic_strb_i = 1'b1;
                @(posedge clk_i);
                #1;
                cordic_strb_i = 1'b0;
                cordic_x_i = 8'($urandom);
                cordic_y_i = 8'($urandom);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_i);
            if (sample_valid_o) begin
                valid_cnt++;
                chk("cos_capture", cos_o, resp_cos);
                chk("sin_capture", sin_o, resp_sin);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
    endtask

    task automatic model_reset;
        m_phase   = '0;
        m_z       = '0;
        m_x       = '0;
        m_ovr     = 1'b0;
        free_edge = 0;
    endtask

    task automatic reset_dut;
        @(negedge clk_i);
        rst_i        = 1'b1;
        sample_req_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        model_reset();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_cos"},   cos_o, 0);
        chk({tag, "_sin"},   sin_o, 0);
        chk({tag, "_z"},     cordic_z_o, 0);
        chk({tag, "_x"},     cordic_x_o, 0);
        chk({tag, "_y"},     cordic_y_o, 0);
        chk({tag, "_flags"}, {cordic_strb_o, sample_valid_o, busy_o, overrun_o, timeout_o}, 0);
    endtask

    // One sample tick; the model decides acceptance from the request spacing rule.
    task automatic do_req(input bit en, input logic [15:0] tune, input logic [7:0] off,
                          input logic [7:0] amp, output bit acc);
        logic [7:0] z_exp;
        int e;
        @(posedge clk_i);
        #1;
        enable_i       = en;
        sample_req_i   = 1'b1;
        tune_word_i    = tune;
        phase_offset_i = off;
        amplitude_i    = amp;
        z_exp          = m_phase[15:8] + off;
        @(posedge clk_i);
        #1;
        sample_req_i = 1'b0;
        e = cyc;
        acc = en && (e >= free_edge);
        if (en) begin
            if (!acc) m_ovr = 1'b1;
            m_phase = m_phase + tune;
        end
        if (acc) begin
            m_z = z_exp;
            m_x = exp_x(amp);
            if (cordic_mute) begin
                free_edge = e + T + 2;
            end else begin
                free_edge = e + 12;
                exp_valid++;
            end
        end
        @(negedge clk_i);
        chk("strobe", cordic_strb_o, acc);
        chk("z_op", cordic_z_o, m_z);
        chk("x_op", cordic_x_o, m_x);
        chk("y_op", cordic_y_o, 0);
        chk("overrun", overrun_o, m_ovr);
    endtask

    initial begin
        bit acc;
        int lat;
        int v0;
        logic [7:0] amp77, cos_keep, sin_keep;
`ifdef CORDIC_SEQ_GAIN_COMP_EN
        amp77 = 8'h7F;
`else
        amp77 = 8'd77;
`endif
        rst_i = 1'b1; enable_i = 1'b0; sample_req_i = 1'b0;
        tune_word_i = '0; phase_offset_i = '0; amplitude_i = '0;
        model_reset();
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_zero("reset");
        #1 rst_i = 1'b0;
        idle(2);
        @(negedge clk_i);
        check_zero("post_reset");

        // Phase sweep 0x00, 0x10, ... across the +pi/-pi wrap
        for (int i = 0; i < 10; i++) begin
            do_req(1'b1, 16'h1000, 8'h00, 8'h7F, acc);
            chk("sweep_acc", acc, 1);
            chk("sweep_z", cordic_z_o, 32'(i * 16));
`ifdef CORDIC_SEQ_GAIN_COMP_EN
            chk("sweep_x", cordic_x_o, 77);
`else
            chk("sweep_x", cordic_x_o, 127);
`endif
            idle(14);
        end
        chk("sweep_valid_cnt", valid_cnt, exp_valid);

        // pi/4 rotation, latency from request to valid
        reset_dut();
        do_req(1'b1, 16'h0000, 8'h20, amp77, acc);
        lat = 0;
        do begin
            @(negedge clk_i);
            lat++;
        end while (!sample_valid_o && lat < 40);
        chk("pi4_latency", lat, 11);
        chk("pi4_cos", cos_o, 54);
        chk("pi4_sin", sin_o, 54);
        @(negedge clk_i);
        chk("pi4_pulse_width", sample_valid_o, 0);
        chk("pi4_busy", busy_o, 0);
        idle(5);

        // Overrun: second request 5 cycles after the first
        reset_dut();
        v0 = valid_cnt;
        do_req(1'b1, 16'h1000, 8'h00, 8'h40, acc);
        idle(3);
        do_req(1'b1, 16'h1000, 8'h00, 8'h40, acc);
        chk("ovr_dropped", acc, 0);
        chk("ovr_flag", overrun_o, 1);
        idle(20);
        chk("ovr_one_valid", valid_cnt - v0, 1);
        do_req(1'b1, 16'h1000, 8'h00, 8'h40, acc);
        chk("ovr_phase_twice", cordic_z_o, 8'h20);
        chk("ovr_sticky", overrun_o, 1);
        idle(14);

        // Timeout with the CORDIC silent
        cos_keep = cos_o;
        sin_keep = sin_o;
        v0 = valid_cnt;
        cordic_mute = 1'b1;
        do_req(1'b1, 16'h1000, 8'h00, 8'h40, acc);
        lat = 0;
        do begin
            @(negedge clk_i);
            lat++;
        end while (!timeout_o && lat < 40);
        chk("tmo_latency", lat, T + 1);
        chk("tmo_busy", busy_o, 0);
        cordic_mute = 1'b0;
        idle(3);
        @(negedge clk_i);
        chk("tmo_cos_held", cos_o, cos_keep);
        chk("tmo_sin_held", sin_o, sin_keep);
        chk("tmo_no_valid", valid_cnt - v0, 0);
        do_req(1'b1, 16'h1000, 8'h00, 8'h40, acc);
        chk("tmo_recover_acc", acc, 1);
        idle(14);
        chk("tmo_sticky", timeout_o, 1);

        // Spurious done strobe while idle
        cos_keep = cos_o;
        v0 = valid_cnt;
        spur_cnt++;
        idle(5);
        @(negedge clk_i);
        chk("spur_cos_held", cos_o, cos_keep);
        chk("spur_no_valid", valid_cnt - v0, 0);
        chk("spur_busy", busy_o, 0);

        // Asynchronous reset in WAIT, CORDIC answers afterwards
        reset_dut();
        v0 = valid_cnt;
        do_req(1'b1, 16'h0000, 8'h20, amp77, acc);
        idle(4);
        #2 rst_i = 1'b1;
        #1;
        check_zero("rst_wait");
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        model_reset();
        exp_valid--;
        idle(15);
        @(negedge clk_i);
        check_zero("rst_late");
        chk("rst_no_valid", valid_cnt - v0, 0);

        // Randomised traffic against the reference model
        reset_dut();
        for (int i = 0; i < 30; i++) begin
            do_req($urandom_range(0, 9) != 0, 16'($urandom), 8'($urandom), 8'($urandom), acc);
            idle($urandom_range(3, 18));
        end
        idle(20);
        @(negedge clk_i);
        chk("rand_valid_cnt", valid_cnt, exp_valid);
        chk("rand_overrun", overrun_o, m_ovr);
        chk("rand_timeout", timeout_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
